// File: rtl/noise_inject_sequencer_pkg.sv
// Shared types and constants for the noise-injection sequencer.
// Imported by the top-level FSM and by the gain ramp.
package noise_inject_sequencer_pkg;

    localparam int AUDIO_W    = 16;
    localparam int GAIN_W_DEF = 8;
    localparam int RAMP_CNT_W = 16;
    localparam int WAIT_CNT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE_L,
        WAIT_L,
        CAP_L,
        DRIVE_R,
        WAIT_R,
        CAP_R,
        DONE
    } seq_state_t;

    localparam seq_state_t           STATE_RST = IDLE;
    localparam logic [AUDIO_W-1:0]   AUDIO_RST = '0;

endpackage

// File: rtl/noise_inject_sequencer_gain_ramp.sv
// Soft gain ramp: moves gain_now one code toward the effective target
// every RAMP_SAMPLES completed frames, so that noise enable/disable never clicks.
module noise_inject_sequencer_gain_ramp
    import noise_inject_sequencer_pkg::*;
#(
    parameter int RAMP_SAMPLES = 256,
    parameter int GAIN_W       = GAIN_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              step,
    input  logic              enable,
    input  logic [GAIN_W-1:0] gain_target,
    output logic [GAIN_W-1:0] gain_now
);

    localparam logic [RAMP_CNT_W-1:0] CNT_LAST = RAMP_CNT_W'(RAMP_SAMPLES - 1);

    logic [RAMP_CNT_W-1:0] ramp_cnt_reg;
    logic [GAIN_W-1:0]     target;

    assign target = enable ? gain_target : '0;

    // Stepping by one toward the target can never overshoot or leave the code range.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ramp_cnt_reg <= '0;
            gain_now     <= '0;
        end else if (step) begin
            if (gain_now == target) begin
                ramp_cnt_reg <= '0;
            end else if (ramp_cnt_reg >= CNT_LAST) begin
                ramp_cnt_reg <= '0;
                if (gain_now < target)
                    gain_now <= gain_now + 1'b1;
                else
                    gain_now <= gain_now - 1'b1;
            end else begin
                ramp_cnt_reg <= ramp_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/noise_inject_sequencer.sv
// Shares one noise-adder datapath between left and right channels each frame,
// with a fixed strobe-to-out_valid latency whether or not the frame is bypassed.
module noise_inject_sequencer
    import noise_inject_sequencer_pkg::*;
#(
    parameter int DP_LATENCY   = 1,
    parameter int RAMP_SAMPLES = 256,
    parameter int GAIN_W       = GAIN_W_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               sample_strobe,
    input  logic [AUDIO_W-1:0] left_in,
    input  logic [AUDIO_W-1:0] right_in,
    input  logic               enable,
    input  logic [GAIN_W-1:0]  gain_target,
    input  logic               clear_ovr,
    output logic [AUDIO_W-1:0] dp_audio_in,
    output logic [GAIN_W-1:0]  dp_gain,
    input  logic [AUDIO_W-1:0] dp_audio_out,
    output logic [AUDIO_W-1:0] left_out,
    output logic [AUDIO_W-1:0] right_out,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun,
    output logic [GAIN_W-1:0]  gain_now
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(DP_LATENCY - 2);

    seq_state_t              state_reg;
    logic [WAIT_CNT_W-1:0]   wait_cnt_reg;
    logic                    bypass_reg;
    logic [AUDIO_W-1:0]      left_lat_reg;
    logic [AUDIO_W-1:0]      right_lat_reg;
    logic                    step;

    assign step    = (state_reg == DONE);
    assign dp_gain = gain_now;

    noise_inject_sequencer_gain_ramp #(
        .RAMP_SAMPLES(RAMP_SAMPLES),
        .GAIN_W      (GAIN_W)
    ) u_gain_ramp (
        .CLK        (CLK),
        .RST        (RST),
        .step       (step),
        .enable     (enable),
        .gain_target(gain_target),
        .gain_now   (gain_now)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg     <= STATE_RST;
            wait_cnt_reg  <= '0;
            bypass_reg    <= 1'b0;
            left_lat_reg  <= AUDIO_RST;
            right_lat_reg <= AUDIO_RST;
            dp_audio_in   <= AUDIO_RST;
            left_out      <= AUDIO_RST;
            right_out     <= AUDIO_RST;
            out_valid     <= 1'b0;
            busy          <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            out_valid <= 1'b0;

            // A new overrun takes priority over a coincident clear.
            if (sample_strobe && (state_reg != IDLE))
                overrun <= 1'b1;
            else if (clear_ovr)
                overrun <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (sample_strobe) begin
                        left_lat_reg  <= left_in;
                        right_lat_reg <= right_in;
                        bypass_reg    <= !enable && (gain_now == '0);
                        dp_audio_in   <= left_in;
                        busy          <= 1'b1;
                        state_reg     <= DRIVE_L;
                    end
                end
                DRIVE_L: begin
                    wait_cnt_reg <= '0;
                    state_reg    <= (DP_LATENCY > 1) ? WAIT_L : CAP_L;
                end
                WAIT_L: begin
                    if (wait_cnt_reg == WAIT_LAST)
                        state_reg <= CAP_L;
                    else
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                end
                CAP_L: begin
                    left_out    <= bypass_reg ? left_lat_reg : dp_audio_out;
                    dp_audio_in <= right_lat_reg;
                    state_reg   <= DRIVE_R;
                end
                DRIVE_R: begin
                    wait_cnt_reg <= '0;
                    state_reg    <= (DP_LATENCY > 1) ? WAIT_R : CAP_R;
                end
                WAIT_R: begin
                    if (wait_cnt_reg == WAIT_LAST)
                        state_reg <= CAP_R;
                    else
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                end
                CAP_R: begin
                    right_out <= bypass_reg ? right_lat_reg : dp_audio_out;
                    out_valid <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noise_inject_sequencer.sv
// Directed bench: two sequencer instances (latency 1 / ramp 4, latency 3 / ramp 2)
// each driving a registered identity+1 datapath model.
module tb_noise_inject_sequencer;

    logic        CLK = 1'b0;
    logic        rst_a, rst_b, strobe_a, strobe_b, enable, clear_ovr;
    logic [15:0] left_in, right_in;
    logic [7:0]  gain_target;

    logic [15:0] dpa_in, dpa_out, lefta, righta;
    logic        ova, busya, ovra;
    logic [7:0]  gna, dpga;
    logic [15:0] dpb_in, dpb_out, leftb, rightb;
    logic        ovb, busyb, ovrb;
    logic [7:0]  gnb, dpgb;
    logic [15:0] pipe_b [0:2];

    int          total = 0;
    int          bad   = 0;
    logic [15:0] dp_log   [0:15];
    logic        busy_log [0:15];
    int          lat, nv;
    logic [15:0] lo, ro;

    always #5 CLK = ~CLK;

    noise_inject_sequencer #(.DP_LATENCY(1), .RAMP_SAMPLES(4), .GAIN_W(8)) dut_a (
        .CLK(CLK), .RST(rst_a), .sample_strobe(strobe_a), .left_in(left_in),
        .right_in(right_in), .enable(enable), .gain_target(gain_target),
        .clear_ovr(clear_ovr), .dp_audio_in(dpa_in), .dp_gain(dpga),
        .dp_audio_out(dpa_out), .left_out(lefta), .right_out(righta),
        .out_valid(ova), .busy(busya), .overrun(ovra), .gain_now(gna)
    );

    noise_inject_sequencer #(.DP_LATENCY(3), .RAMP_SAMPLES(2), .GAIN_W(8)) dut_b (
        .CLK(CLK), .RST(rst_b), .sample_strobe(strobe_b), .left_in(left_in),
        .right_in(right_in), .enable(enable), .gain_target(gain_target),
        .clear_ovr(clear_ovr), .dp_audio_in(dpb_in), .dp_gain(dpgb),
        .dp_audio_out(dpb_out), .left_out(leftb), .right_out(rightb),
        .out_valid(ovb), .busy(busyb), .overrun(ovrb), .gain_now(gnb)
    );

    // Datapath models: identity+1 with one and three register stages.
    always_ff @(posedge CLK) dpa_out <= dpa_in + 16'd1;
    always_ff @(posedge CLK) begin
        pipe_b[0] <= dpb_in + 16'd1;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign dpb_out = pipe_b[2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One frame: strobe, then watch 14 cycles; optional second strobe at cycle extra_at.
    task automatic run_frame(input bit sel, input logic [15:0] l, input logic [15:0] r,
                             input int extra_at, input bit clr_too,
                             output int lat_o, output int nval,
                             output logic [15:0] lo_o, output logic [15:0] ro_o);
        lat_o = 0; nval = 0; lo_o = '0; ro_o = '0;
        @(negedge CLK);
        left_in = l; right_in = r;
        if (sel) strobe_b = 1'b1; else strobe_a = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge CLK);
            strobe_a = 1'b0; strobe_b = 1'b0; clear_ovr = 1'b0;
            dp_log[k]   = sel ? dpb_in : dpa_in;
            busy_log[k] = sel ? busyb : busya;
            if (sel ? ovb : ova) begin
                nval++;
                if (lat_o == 0) begin
                    lat_o = k;
                    lo_o  = sel ? leftb : lefta;
                    ro_o  = sel ? rightb : righta;
                end
            end
            if (k == extra_at) begin
                left_in = l ^ 16'h5555; right_in = r ^ 16'h5555;
                if (sel) strobe_b = 1'b1; else strobe_a = 1'b1;
                if (clr_too) clear_ovr = 1'b1;
            end
        end
        $display("frame dut=%s L=%h R=%h lat=%0d out=%h/%h valids=%0d gain=%0d",
                 sel ? "b" : "a", l, r, lat_o, lo_o, ro_o, nval, sel ? gnb : gna);
    endtask

    initial begin
        int seen;
        int expg;
        rst_a = 1'b0; rst_b = 1'b0; strobe_a = 1'b0; strobe_b = 1'b0;
        enable = 1'b0; clear_ovr = 1'b0; left_in = '0; right_in = '0; gain_target = '0;
        repeat (3) @(negedge CLK);
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge CLK);
        chk("rst_left", lefta, 0);
        chk("rst_right", righta, 0);
        chk("rst_valid", ova, 0);
        chk("rst_busy", busya, 0);
        chk("rst_ovr", ovra, 0);
        chk("rst_gain", gna, 0);
        chk("rst_dpgain", dpga, 0);
        chk("rst_dpin", dpa_in, 0);

        // Basic processed frame through the latency-1 datapath.
        enable = 1'b1; gain_target = 8'd0;
        run_frame(0, 16'd100, 16'hFF38, 0, 0, lat, nv, lo, ro);
        chk("t1_lat", lat, 5);
        chk("t1_nvalid", nv, 1);
        chk("t1_dp_l", dp_log[1], 16'd100);
        chk("t1_dp_r", dp_log[3], 16'hFF38);
        chk("t1_left", lo, 16'd101);
        chk("t1_right", ro, 16'hFF39);
        chk("t1_busy_on", busy_log[1], 1);
        chk("t1_busy_done", busy_log[5], 1);
        chk("t1_busy_off", busy_log[6], 0);

        // Bypass: raw samples pass, datapath result ignored, same latency.
        enable = 1'b0;
        run_frame(0, 16'h7FFF, 16'h8000, 0, 0, lat, nv, lo, ro);
        chk("byp_lat", lat, 5);
        chk("byp_left", lo, 16'h7FFF);
        chk("byp_right", ro, 16'h8000);

        // Overrun: second strobe two cycles in is dropped.
        enable = 1'b1;
        run_frame(0, 16'd11, 16'd22, 2, 0, lat, nv, lo, ro);
        chk("ovr_nvalid", nv, 1);
        chk("ovr_lat", lat, 5);
        chk("ovr_left", lo, 16'd12);
        chk("ovr_right", ro, 16'd23);
        chk("ovr_set", ovra, 1);
        @(negedge CLK); clear_ovr = 1'b1;
        @(negedge CLK); clear_ovr = 1'b0;
        chk("ovr_cleared", ovra, 0);
        run_frame(0, 16'd33, 16'd44, 2, 0, lat, nv, lo, ro);
        chk("ovr_set2", ovra, 1);
        run_frame(0, 16'd55, 16'd66, 3, 1, lat, nv, lo, ro);
        chk("ovr_set_wins", ovra, 1);
        chk("ovr_set_wins_left", lo, 16'd56);
        @(negedge CLK); clear_ovr = 1'b1;
        @(negedge CLK); clear_ovr = 1'b0;

        // Ramp up to 3, one step every 4 frames.
        gain_target = 8'd3;
        for (int f = 1; f <= 20; f++) begin
            run_frame(0, 16'(1000 + f), 16'(2000 + f), 0, 0, lat, nv, lo, ro);
            expg = (f / 4 > 3) ? 3 : f / 4;
            chk("ramp_up_gain", gna, expg);
        end
        chk("ramp_dpgain", dpga, 3);
        chk("ramp_up_left", lo, 16'd1021);

        // Disable: ramp down over 12 frames, then bypass.
        enable = 1'b0;
        for (int f = 1; f <= 13; f++) begin
            run_frame(0, 16'(3000 + f), 16'(4000 + f), 0, 0, lat, nv, lo, ro);
            expg = (3 - f / 4 < 0) ? 0 : 3 - f / 4;
            chk("ramp_dn_gain", gna, expg);
            chk("ramp_dn_left", lo, (f <= 12) ? 16'(3000 + f + 1) : 16'(3000 + f));
        end

        // Latency-3 instance: two-cycle WAIT states, out_valid at cycle 9.
        enable = 1'b1; gain_target = 8'd0;
        run_frame(1, 16'd500, 16'hFFF9, 0, 0, lat, nv, lo, ro);
        chk("l3_lat", lat, 9);
        chk("l3_nvalid", nv, 1);
        chk("l3_dp_l", dp_log[1], 16'd500);
        chk("l3_dp_hold", dp_log[3], 16'd500);
        chk("l3_dp_r", dp_log[5], 16'hFFF9);
        chk("l3_left", lo, 16'd501);
        chk("l3_right", ro, 16'hFFFA);

        // Asynchronous reset during WAIT_R aborts the frame.
        @(negedge CLK);
        left_in = 16'd40; right_in = 16'd50; strobe_b = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            strobe_b = 1'b0;
        end
        chk("rst_mid_busy_before", busyb, 1);
        chk("rst_mid_left_before", leftb, 16'd41);
        #1 rst_b = 1'b0;
        #1;
        chk("rst_mid_left", leftb, 0);
        chk("rst_mid_busy", busyb, 0);
        chk("rst_mid_dpin", dpb_in, 0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            if (k == 1) rst_b = 1'b1;
            if (ovb) seen++;
        end
        chk("rst_mid_no_valid", seen, 0);
        run_frame(1, 16'd20, 16'd30, 0, 0, lat, nv, lo, ro);
        chk("rst_after_lat", lat, 9);
        chk("rst_after_left", lo, 16'd21);
        chk("rst_after_right", ro, 16'd31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
